uart_rx_frontend: RTL and testbench

- UART receiver stage sitting directly upstream of the SoC core's `uart_rx` input path.
- Synchronises the raw serial pin and oversamples it, then de-frames 8N1 characters.
- Delivers each byte to the core over a registered valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses so the core or a status register can count them.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_frontend_if.sv | 30 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_frontend.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive front end and the transmit stage.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS          = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte delivery handshake and status pulses between the UART receiver and the core.
interface uart_rx_frontend_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable to
// phase-align sampling with a detected start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter: wraps at DIV-1, forced to zero on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: pin synchroniser, oversampled de-framing FSM and a
// single-entry holding register presented over a valid/ready handshake.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  uart_rx_frontend_if.master rx_if
);

  localparam int unsigned       DIV       = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned       SAMP_W    = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rx_s;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic                 wait_high;
  uart_state_e          state;
  uart_state_e          state_nxt;
  logic                 tick;
  logic                 restart;
  logic                 start_ok;
  logic                 mid_start;
  logic                 mid_bit;
  logic                 byte_done;
  logic                 stop_bad;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // Two-flop synchroniser, preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // Arm on a real high line. sync_fill marks when rx_s carries pin data rather
  // than the reset preset, so releasing reset mid-frame cannot arm falsely.
  // wait_high blocks restart after a bad stop bit until the line returns high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_fill <= '0;
      armed     <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (rx_s & sync_fill[1]);
      if (stop_bad) begin
        wait_high <= 1'b1;
      end else if (rx_s) begin
        wait_high <= 1'b0;
      end
    end
  end

  assign start_ok  = armed && !wait_high && !rx_s;
  assign mid_start = tick && (samp_cnt == SAMP_MID);
  assign mid_bit   = tick && (samp_cnt == SAMP_LAST);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = START;
      START: if (mid_start) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (mid_bit && (bit_cnt == BIT_LAST)) state_nxt = STOP;
      STOP:  if (mid_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy level, tick restart and stop-bit verdict strobes.
  always_comb begin
    rx_if.busy = (state != IDLE);
    restart    = 1'b0;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: restart = start_ok;
      STOP: begin
        byte_done = mid_bit && rx_s;
        stop_bad  = mid_bit && !rx_s;
      end
      default: ;
    endcase
  end

  // Sample and bit counters plus the LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) samp_cnt <= '0;
        START: begin
          if (mid_start) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
          end else if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end
        DATA: begin
          if (mid_bit) begin
            samp_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
          end else if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end
        STOP: begin
          if (mid_bit) begin
            samp_cnt <= '0;
          end else if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Holding register and handshake; a byte arriving while the slot is full
  // and not being drained is dropped and reported as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.rx_data   <= '0;
      rx_if.rx_valid  <= 1'b0;
      rx_if.frame_err <= 1'b0;
      rx_if.overrun   <= 1'b0;
    end else begin
      rx_if.frame_err <= stop_bad;
      rx_if.overrun   <= byte_done && rx_if.rx_valid && !rx_if.rx_ready;
      if (byte_done && (!rx_if.rx_valid || rx_if.rx_ready)) begin
        rx_if.rx_data  <= shift;
        rx_if.rx_valid <= 1'b1;
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend at 16 clocks per bit.
module tb_uart_rx_frontend;

  localparam int unsigned CLK_HZ   = 16000000;
  localparam int unsigned BAUD     = 1000000;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CLKS = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_rx = 1'b1;

  uart_rx_frontend_if rx_if ();

  uart_rx_frontend #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .uart_rx(uart_rx),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records handshakes and pulse statistics.
  logic [7:0] got_q[$];
  int   fe_cnt = 0, ov_cnt = 0, fe_long = 0, busy_cnt = 0, stable_err = 0, rise_cyc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_fe = 1'b0;
  logic [7:0] prev_d = '0;

  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
    if (rx_if.frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_if.frame_err && prev_fe) fe_long <= fe_long + 1;
    if (rx_if.overrun) ov_cnt <= ov_cnt + 1;
    if (rx_if.busy) busy_cnt <= busy_cnt + 1;
    if (rx_if.rx_valid && !prev_v) rise_cyc <= cyc;
    if (rst_n && prev_v && !prev_r && (!rx_if.rx_valid || rx_if.rx_data != prev_d))
      stable_err <= stable_err + 1;
    prev_v  <= rx_if.rx_valid;
    prev_r  <= rx_if.rx_ready;
    prev_fe <= rx_if.frame_err;
    prev_d  <= rx_if.rx_data;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_beats;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, fe0, ov0, b0, lat;
    int  fe_exp, ov_exp;
    logic held;
    logic [7:0] held_byte;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b0, 0, 1};

    rx_if.rx_ready = 1'b1;
    @(posedge clk); #1;
    idle(3);
    check("reset_valid", int'(rx_if.rx_valid), 0);
    check("reset_data", int'(rx_if.rx_data), 0);
    check("reset_frame_err", int'(rx_if.frame_err), 0);
    check("reset_overrun", int'(rx_if.overrun), 0);
    check("reset_busy", int'(rx_if.busy), 0);
    rst_n = 1'b1;
    idle(8);
    check("post_reset_busy", int'(rx_if.busy), 0);

    // Table-driven single frames.
    foreach (vecs[k]) begin
      base = got_q.size();
      fe0  = fe_cnt;
      ov0  = ov_cnt;
      send_frame(vecs[k].data, vecs[k].stop_ok);
      uart_rx = 1'b1;
      idle(3 * BIT_CLKS);
      check($sformatf("vec%0d_beats", k), got_q.size() - base, vecs[k].exp_beats);
      if (vecs[k].exp_beats == 1 && got_q.size() > base)
        check($sformatf("vec%0d_data", k), int'(got_q[base]), int'(vecs[k].data));
      check($sformatf("vec%0d_frame_err", k), fe_cnt - fe0, vecs[k].exp_fe);
      check($sformatf("vec%0d_overrun", k), ov_cnt - ov0, 0);
      check($sformatf("vec%0d_valid_idle", k), int'(rx_if.rx_valid), 0);
    end

    // 0xA5 latency from pin falling edge to rx_valid.
    base = got_q.size();
    send_frame(8'hA5, 1'b1);
    idle(2 * BIT_CLKS);
    lat = rise_cyc - fall_cyc;
    check("a5_latency_in_window", int'(lat >= 155 && lat <= 160), 1);
    check("a5_beats", got_q.size() - base, 1);
    if (got_q.size() > base) check("a5_data", int'(got_q[base]), 'hA5);

    // Back-to-back frames with a single stop bit.
    base = got_q.size();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(3 * BIT_CLKS);
    check("b2b_beats", got_q.size() - base, 2);
    if (got_q.size() >= base + 2) begin
      check("b2b_first", int'(got_q[base]), 'h3C);
      check("b2b_second", int'(got_q[base+1]), 'hC3);
    end

    // Framing error followed by a long break.
    base = got_q.size();
    fe0  = fe_cnt;
    send_frame(8'h55, 1'b0);
    b0 = busy_cnt;
    repeat (40) drive_bit(1'b0);
    check("break_frame_err_count", fe_cnt - fe0, 1);
    check("break_pulse_width", fe_long, 0);
    check("break_beats", got_q.size() - base, 0);
    check("break_valid", int'(rx_if.rx_valid), 0);
    check("break_busy_cycles", busy_cnt - b0, 0);
    uart_rx = 1'b1;
    idle(2 * BIT_CLKS);

    // Overrun with the consumer stalled.
    rx_if.rx_ready = 1'b0;
    base = got_q.size();
    ov0  = ov_cnt;
    send_frame(8'h11, 1'b1);
    idle(8);
    send_frame(8'h22, 1'b1);
    idle(2 * BIT_CLKS);
    check("ovr_valid_held", int'(rx_if.rx_valid), 1);
    check("ovr_data_held", int'(rx_if.rx_data), 'h11);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_no_beat", got_q.size() - base, 0);
    rx_if.rx_ready = 1'b1;
    idle(4);
    check("ovr_drain_beats", got_q.size() - base, 1);
    if (got_q.size() > base) check("ovr_drain_data", int'(got_q[base]), 'h11);
    check("ovr_valid_cleared", int'(rx_if.rx_valid), 0);

    // Short glitch: start is rejected at the start-bit midpoint.
    base = got_q.size();
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    b0   = busy_cnt;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(3 * BIT_CLKS);
    check("glitch_busy_seen", int'((busy_cnt - b0) > 0 && (busy_cnt - b0) <= BIT_CLKS), 1);
    check("glitch_back_idle", int'(rx_if.busy), 0);
    check("glitch_no_output", got_q.size() - base + fe_cnt - fe0 + ov_cnt - ov0, 0);

    // Reset mid-frame, released while the line is low.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    idle(8);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    b0 = busy_cnt;
    idle(2 * BIT_CLKS);
    check("rst_mid_no_start", busy_cnt - b0, 0);
    uart_rx = 1'b1;
    idle(BIT_CLKS);
    base = got_q.size();
    fe0  = fe_cnt;
    send_frame(8'h7E, 1'b1);
    idle(3 * BIT_CLKS);
    check("rst_mid_beats", got_q.size() - base, 1);
    if (got_q.size() > base) check("rst_mid_data", int'(got_q[base]), 'h7E);
    check("rst_mid_frame_err", fe_cnt - fe0, 0);

    // Randomized frames against a one-slot holding-buffer model.
    base   = got_q.size();
    fe0    = fe_cnt;
    ov0    = ov_cnt;
    fe_exp = 0;
    ov_exp = 0;
    held   = 1'b0;
    held_byte = '0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic stop_ok, rdy;
      int gap;
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 9) != 0);
      rdy     = ($urandom_range(0, 3) != 0);
      gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      rx_if.rx_ready = rdy;
      if (rdy && held) begin
        exp_q.push_back(held_byte);
        held = 1'b0;
      end
      send_frame(d, stop_ok);
      if (!stop_ok) fe_exp++;
      else if (held) ov_exp++;
      else if (rdy) exp_q.push_back(d);
      else begin
        held      = 1'b1;
        held_byte = d;
      end
      uart_rx = 1'b1;
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    rx_if.rx_ready = 1'b1;
    if (held) exp_q.push_back(held_byte);
    idle(2 * BIT_CLKS);
    check("rand_beats", got_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i < got_q.size())
        check($sformatf("rand_data%0d", i), int'(got_q[base+i]), int'(exp_q[i]));
    check("rand_frame_err", fe_cnt - fe0, fe_exp);
    check("rand_overrun", ov_cnt - ov0, ov_exp);

    check("data_stable_while_stalled", stable_err, 0);
    check("frame_err_single_cycle", fe_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
